// File: rtl/inst_fetch_responder.sv
// Instruction-side memory responder.
// Serves fetch-stage PC requests from a one-line (64-bit) buffer. On a miss it
// runs a req/grant/rvalid read to instruction memory and stalls fetch until the
// data returns. A redirect (flush_i) either drops an ungranted request or lets
// an in-flight read drain into the buffer without delivering an instruction.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | no transaction in flight; hits served from the line buffer
// S_REQ   | mem_req_o asserted, waiting for mem_gnt_i
// S_WAIT  | request granted, waiting for mem_rvalid_i
// S_DRAIN | fetch squashed after grant; absorb read data, deliver nothing

module inst_fetch_responder #(
  parameter int ADDR_W = 64,
  parameter bit BUF_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              pc_en_i,
  input  logic              flush_i,
  output logic [31:0]       inst_o,
  output logic              inst_valid_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [63:0]       mem_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ADDR_W-4:0] buf_tag;
  logic [63:0]       buf_data;
  logic              buf_valid;
  logic              half_sel;
  logic              valid_q;

  logic hit;
  logic issue;
  logic hit_take;
  logic accept;
  logic deliver;
  logic req_clear;

  // The byte offset within a 32-bit word never affects the fetched word.
  logic unused_pc_bits;
  assign unused_pc_bits = ^pc_i[1:0];

  assign hit = BUF_EN && buf_valid && (buf_tag == pc_i[ADDR_W-1:3]);

  // A coincident redirect suppresses the pending instruction pulse.
  assign inst_valid_o = valid_q && !flush_i;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (pc_en_i && !hit) begin
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_gnt_i) begin
          if (mem_rvalid_i) begin
            state_nxt = S_IDLE;
          end else if (flush_i) begin
            state_nxt = S_DRAIN;
          end else begin
            state_nxt = S_WAIT;
          end
        end else if (flush_i) begin
          state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (mem_rvalid_i) begin
          state_nxt = S_IDLE;
        end else if (flush_i) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (mem_rvalid_i) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output and datapath-control decode.
  always_comb begin
    issue     = (state == S_IDLE) && pc_en_i && !hit;
    hit_take  = (state == S_IDLE) && pc_en_i && hit;
    accept    = mem_rvalid_i &&
                ((state == S_WAIT) || (state == S_DRAIN) ||
                 ((state == S_REQ) && mem_gnt_i));
    // Data that lands with a redirect, or while draining, only fills the buffer.
    deliver   = accept && (state != S_DRAIN) && !flush_i;
    req_clear = (state == S_REQ) && (mem_gnt_i || flush_i);
    stall_o   = !rst && ((state != S_IDLE) || issue);
  end

  // Instruction return, memory request and line buffer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_o     <= 32'h0;
      valid_q    <= 1'b0;
      mem_req_o  <= 1'b0;
      mem_addr_o <= '0;
      half_sel   <= 1'b0;
      buf_valid  <= 1'b0;
      buf_tag    <= '0;
      buf_data   <= 64'h0;
    end else begin
      valid_q <= 1'b0;
      if (hit_take) begin
        inst_o  <= pc_i[2] ? buf_data[63:32] : buf_data[31:0];
        valid_q <= 1'b1;
      end else if (deliver) begin
        inst_o  <= half_sel ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
        valid_q <= 1'b1;
      end

      if (issue) begin
        mem_req_o  <= 1'b1;
        mem_addr_o <= {pc_i[ADDR_W-1:3], 3'b000};
        half_sel   <= pc_i[2];
      end else if (req_clear) begin
        mem_req_o <= 1'b0;
      end

      if (accept) begin
        buf_valid <= 1'b1;
        buf_tag   <= mem_addr_o[ADDR_W-1:3];
        buf_data  <= mem_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Directed bench for inst_fetch_responder: miss/hit paths, delayed grant,
// redirects in IDLE/REQ/WAIT, and reset in the middle of a transaction.

module tb_inst_fetch_responder;

  logic        clk;
  logic        rst;
  logic [63:0] pc_i;
  logic        pc_en_i;
  logic        flush_i;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        stall_o;
  logic        mem_req_o;
  logic [63:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [63:0] mem_rdata_i;

  int n_checks;
  int n_fail;
  int pulses;

  inst_fetch_responder #(.ADDR_W(64), .BUF_EN(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_i         (pc_i),
    .pc_en_i      (pc_en_i),
    .flush_i      (flush_i),
    .inst_o       (inst_o),
    .inst_valid_o (inst_valid_o),
    .stall_o      (stall_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count delivered instruction pulses, sampled mid-cycle.
  always @(negedge clk) begin
    #3;
    if (inst_valid_o === 1'b1) pulses++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    @(negedge clk); rst = 1'b1; pc_en_i = 1'b1; pc_i = 64'h8000_0000; #1;
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL rst_stall_forced: got %b want 0", stall_o); end
    @(negedge clk); #1;
    n_checks++; if (inst_o !== 32'h0) begin n_fail++; $display("FAIL rst_inst: got %h want 0", inst_o); end
    n_checks++; if (inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", inst_valid_o); end
    n_checks++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", mem_req_o); end
    n_checks++; if (mem_addr_o !== 64'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", mem_addr_o); end
    pc_en_i = 1'b0;
  endtask

  task automatic test_miss();
    @(negedge clk); rst = 1'b0; pc_i = 64'h8000_0000; pc_en_i = 1'b1; #1;
    n_checks++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL miss_stall_comb: got %b want 1", stall_o); end
    @(negedge clk); pc_en_i = 1'b0; mem_gnt_i = 1'b1; #1;
    n_checks++; if (mem_req_o !== 1'b1) begin n_fail++; $display("FAIL miss_req: got %b want 1", mem_req_o); end
    n_checks++; if (mem_addr_o !== 64'h8000_0000) begin n_fail++; $display("FAIL miss_addr: got %h want 80000000", mem_addr_o); end
    n_checks++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL miss_stall_req: got %b want 1", stall_o); end
    @(negedge clk); mem_gnt_i = 1'b0; #1;
    n_checks++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL miss_req_drop: got %b want 0", mem_req_o); end
    n_checks++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL miss_stall_wait: got %b want 1", stall_o); end
    @(negedge clk); #1;
    n_checks++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL miss_stall_wait2: got %b want 1", stall_o); end
    @(negedge clk); mem_rvalid_i = 1'b1; mem_rdata_i = 64'h0000_0013_0010_0093; #1;
    n_checks++; if (inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL miss_early_valid: got %b want 0", inst_valid_o); end
    @(negedge clk); mem_rvalid_i = 1'b0; #1;
    n_checks++; if (inst_valid_o !== 1'b1) begin n_fail++; $display("FAIL miss_valid: got %b want 1", inst_valid_o); end
    n_checks++; if (inst_o !== 32'h0010_0093) begin n_fail++; $display("FAIL miss_inst: got %h want 00100093", inst_o); end
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL miss_stall_done: got %b want 0", stall_o); end
    @(negedge clk); #1;
    n_checks++; if (inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL miss_pulse_width: got %b want 0", inst_valid_o); end
  endtask

  task automatic test_hit();
    @(negedge clk); pc_i = 64'h8000_0004; pc_en_i = 1'b1; #1;
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL hit_stall: got %b want 0", stall_o); end
    @(negedge clk); pc_en_i = 1'b0; #1;
    n_checks++; if (inst_valid_o !== 1'b1) begin n_fail++; $display("FAIL hit_valid: got %b want 1", inst_valid_o); end
    n_checks++; if (inst_o !== 32'h0000_0013) begin n_fail++; $display("FAIL hit_inst: got %h want 00000013", inst_o); end
    n_checks++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL hit_no_req: got %b want 0", mem_req_o); end
    @(negedge clk); #1;
    n_checks++; if (inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL hit_pulse_width: got %b want 0", inst_valid_o); end
  endtask

  task automatic test_gnt_delay();
    int p0;
    p0 = pulses;
    @(negedge clk); pc_i = 64'h8000_0008; pc_en_i = 1'b1; #1;
    n_checks++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL dly_stall: got %b want 1", stall_o); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); pc_en_i = 1'b0; #1;
      n_checks++;
      if (mem_req_o !== 1'b1 || mem_addr_o !== 64'h8000_0008) begin
        n_fail++; $display("FAIL dly_hold[%0d]: got req=%b addr=%h want req=1 addr=80000008", i, mem_req_o, mem_addr_o);
      end
    end
    @(negedge clk); mem_gnt_i = 1'b1; #1;
    n_checks++; if (mem_req_o !== 1'b1) begin n_fail++; $display("FAIL dly_req_at_gnt: got %b want 1", mem_req_o); end
    @(negedge clk); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 64'h2222_2222_1111_1111; #1;
    n_checks++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL dly_req_drop: got %b want 0", mem_req_o); end
    @(negedge clk); mem_rvalid_i = 1'b0; #1;
    n_checks++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h1111_1111) begin
      n_fail++; $display("FAIL dly_inst: got valid=%b inst=%h want valid=1 inst=11111111", inst_valid_o, inst_o);
    end
    @(negedge clk); @(negedge clk); #4;
    n_checks++; if (pulses - p0 != 1) begin n_fail++; $display("FAIL dly_pulse_count: got %0d want 1", pulses - p0); end
  endtask

  task automatic test_flush_wait();
    int p0;
    p0 = pulses;
    @(negedge clk); pc_i = 64'h8000_0010; pc_en_i = 1'b1; #1;
    n_checks++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL fw_stall: got %b want 1", stall_o); end
    @(negedge clk); pc_en_i = 1'b0; mem_gnt_i = 1'b1; #1;
    n_checks++; if (mem_addr_o !== 64'h8000_0010) begin n_fail++; $display("FAIL fw_addr: got %h want 80000010", mem_addr_o); end
    @(negedge clk); mem_gnt_i = 1'b0; flush_i = 1'b1; #1;
    @(negedge clk); flush_i = 1'b0; #1;
    n_checks++; if (stall_o !== 1'b1 || mem_req_o !== 1'b0) begin
      n_fail++; $display("FAIL fw_drain: got stall=%b req=%b want stall=1 req=0", stall_o, mem_req_o);
    end
    @(negedge clk); mem_rvalid_i = 1'b1; mem_rdata_i = 64'hAAAA_AAAA_BBBB_BBBB; #1;
    @(negedge clk); mem_rvalid_i = 1'b0; #1;
    n_checks++; if (inst_valid_o !== 1'b0 || stall_o !== 1'b0) begin
      n_fail++; $display("FAIL fw_no_deliver: got valid=%b stall=%b want 0 0", inst_valid_o, stall_o);
    end
    @(negedge clk); #4;
    n_checks++; if (pulses != p0) begin n_fail++; $display("FAIL fw_pulse_count: got %0d want 0", pulses - p0); end
    @(negedge clk); pc_i = 64'h8000_0014; pc_en_i = 1'b1; #1;
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL fw_hit_stall: got %b want 0", stall_o); end
    @(negedge clk); pc_en_i = 1'b0; #1;
    n_checks++; if (inst_valid_o !== 1'b1 || inst_o !== 32'hAAAA_AAAA || mem_req_o !== 1'b0) begin
      n_fail++; $display("FAIL fw_hit_inst: got valid=%b inst=%h req=%b want 1 aaaaaaaa 0", inst_valid_o, inst_o, mem_req_o);
    end
  endtask

  task automatic test_flush_idle();
    @(negedge clk); pc_i = 64'h8000_0010; pc_en_i = 1'b1; #1;
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL fi_stall: got %b want 0", stall_o); end
    @(negedge clk); pc_en_i = 1'b0; flush_i = 1'b1; #1;
    n_checks++; if (inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL fi_suppress: got %b want 0", inst_valid_o); end
    n_checks++; if (inst_o !== 32'hBBBB_BBBB) begin n_fail++; $display("FAIL fi_low_half: got %h want bbbbbbbb", inst_o); end
    @(negedge clk); flush_i = 1'b0; #1;
    n_checks++; if (inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL fi_after: got %b want 0", inst_valid_o); end
  endtask

  task automatic test_flush_req();
    @(negedge clk); pc_i = 64'h8000_0020; pc_en_i = 1'b1; #1;
    n_checks++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL fr_stall: got %b want 1", stall_o); end
    @(negedge clk); pc_en_i = 1'b0; flush_i = 1'b1; #1;
    n_checks++; if (mem_req_o !== 1'b1) begin n_fail++; $display("FAIL fr_req: got %b want 1", mem_req_o); end
    @(negedge clk); flush_i = 1'b0; #1;
    n_checks++; if (mem_req_o !== 1'b0 || stall_o !== 1'b0) begin
      n_fail++; $display("FAIL fr_dropped: got req=%b stall=%b want 0 0", mem_req_o, stall_o);
    end
    @(negedge clk); pc_i = 64'h8000_0014; pc_en_i = 1'b1; #1;
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL fr_buf_kept: got stall=%b want 0", stall_o); end
    @(negedge clk); pc_en_i = 1'b0; #1;
    n_checks++; if (inst_valid_o !== 1'b1 || inst_o !== 32'hAAAA_AAAA) begin
      n_fail++; $display("FAIL fr_buf_inst: got valid=%b inst=%h want 1 aaaaaaaa", inst_valid_o, inst_o);
    end
    @(negedge clk); pc_i = 64'h8000_0020; pc_en_i = 1'b1; #1;
    @(negedge clk); pc_en_i = 1'b0; mem_gnt_i = 1'b1; #1;
    n_checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 64'h8000_0020) begin
      n_fail++; $display("FAIL fr_retry_req: got req=%b addr=%h want 1 80000020", mem_req_o, mem_addr_o);
    end
    @(negedge clk); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 64'h4444_4444_3333_3333; #1;
    @(negedge clk); mem_rvalid_i = 1'b0; #1;
    n_checks++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h3333_3333) begin
      n_fail++; $display("FAIL fr_retry_inst: got valid=%b inst=%h want 1 33333333", inst_valid_o, inst_o);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); pc_i = 64'h8000_0040; pc_en_i = 1'b1; #1;
    n_checks++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL rm_stall: got %b want 1", stall_o); end
    @(negedge clk); pc_en_i = 1'b0; mem_gnt_i = 1'b1; #1;
    @(negedge clk); mem_gnt_i = 1'b0; rst = 1'b1; #1;
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL rm_stall_forced: got %b want 0", stall_o); end
    @(negedge clk); rst = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 64'h7777_7777_8888_8888; #1;
    n_checks++; if (stall_o !== 1'b0 || mem_req_o !== 1'b0) begin
      n_fail++; $display("FAIL rm_idle: got stall=%b req=%b want 0 0", stall_o, mem_req_o);
    end
    @(negedge clk); mem_rvalid_i = 1'b0; #1;
    n_checks++; if (inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL rm_late_rvalid: got %b want 0", inst_valid_o); end
    // Line 0x80000020 was buffered before reset; it must miss now.
    @(negedge clk); pc_i = 64'h8000_0024; pc_en_i = 1'b1; #1;
    n_checks++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL rm_buf_cleared: got stall=%b want 1", stall_o); end
    @(negedge clk); pc_en_i = 1'b0; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 64'h5555_5555_6666_6666; #1;
    n_checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 64'h8000_0020) begin
      n_fail++; $display("FAIL rm_req_addr: got req=%b addr=%h want 1 80000020", mem_req_o, mem_addr_o);
    end
    @(negedge clk); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; #1;
    n_checks++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h5555_5555 || mem_req_o !== 1'b0) begin
      n_fail++; $display("FAIL rm_gnt_rvalid: got valid=%b inst=%h req=%b want 1 55555555 0", inst_valid_o, inst_o, mem_req_o);
    end
    @(negedge clk); pc_i = 64'h8000_0004; pc_en_i = 1'b1; #1;
    n_checks++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL rm_next_miss: got stall=%b want 1", stall_o); end
    @(negedge clk); pc_en_i = 1'b0; #1;
    n_checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 64'h8000_0000) begin
      n_fail++; $display("FAIL rm_next_addr: got req=%b addr=%h want 1 80000000", mem_req_o, mem_addr_o);
    end
    @(negedge clk); flush_i = 1'b1; #1;
    @(negedge clk); flush_i = 1'b0; #1;
    n_checks++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL rm_final_drop: got %b want 0", mem_req_o); end
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    pulses       = 0;
    rst          = 1'b1;
    pc_i         = 64'h0;
    pc_en_i      = 1'b0;
    flush_i      = 1'b0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 64'h0;

    test_reset();
    test_miss();
    test_hit();
    test_gnt_delay();
    test_flush_wait();
    test_flush_idle();
    test_flush_req();
    test_reset_mid();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
